// File: rtl/freq_meter.sv
// Beat-interval meter: counts enabled ticks between rising edges of a synchronous
// pulse and reports the interval as a divider code, with lock and overflow flags.
module freq_meter #(
  parameter int WIDTH        = 4,
  parameter int LOCK_MATCHES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             count,
  input  logic             pulse,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             locked,
  output logic             overflow,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEASURE = 2'b01,
    OVER    = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [3:0]       LOCK_TH = 4'(LOCK_MATCHES);

  state_t           state_r;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] period_r;
  logic             valid_r;
  logic             locked_r;
  logic             overflow_r;
  logic [3:0]       match_r;
  logic             pulse_q_r;
  logic             edge_s;
  logic [3:0]       match_nxt_s;

  assign edge_s = pulse & ~pulse_q_r;

  // Next match count for a measurement completing this cycle (saturates at 15)
  always_comb begin
    match_nxt_s = 4'd1;
    if ((cnt_r == period_r) && (match_r != 4'd0)) begin
      if (match_r == 4'd15) begin
        match_nxt_s = 4'd15;
      end else begin
        match_nxt_s = match_r + 4'd1;
      end
    end else begin
      match_nxt_s = 4'd1;
    end
  end

  // Edge register, interval counter, measurement FSM and flags
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      period_r   <= '0;
      valid_r    <= 1'b0;
      locked_r   <= 1'b0;
      overflow_r <= 1'b0;
      match_r    <= 4'd0;
      pulse_q_r  <= 1'b1;
    end else begin
      pulse_q_r <= pulse;
      valid_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (edge_s) begin
            state_r <= MEASURE;
            cnt_r   <= '0;
          end
        end
        MEASURE: begin
          // An edge wins over a coincident tick, including the overflowing one
          if (edge_s) begin
            period_r   <= cnt_r;
            valid_r    <= 1'b1;
            overflow_r <= 1'b0;
            match_r    <= match_nxt_s;
            locked_r   <= (match_nxt_s >= LOCK_TH);
            cnt_r      <= '0;
          end else if (count) begin
            if (cnt_r == CNT_MAX) begin
              state_r    <= OVER;
              overflow_r <= 1'b1;
              locked_r   <= 1'b0;
              match_r    <= 4'd0;
            end else begin
              cnt_r <= cnt_r + WIDTH'(1);
            end
          end
        end
        OVER: begin
          if (edge_s) begin
            state_r <= MEASURE;
            cnt_r   <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign period   = period_r;
  assign valid    = valid_r;
  assign locked   = locked_r;
  assign overflow = overflow_r;
  assign state    = state_r;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: directed pulse trains push expected measurements,
// a negedge monitor pops and compares them whenever valid is high.
module tb_freq_meter;

  logic       clk;
  logic       clr;
  logic       count;
  logic       pulse;
  logic [3:0] period;
  logic       valid;
  logic       locked;
  logic       overflow;
  logic [1:0] state;

  typedef struct {
    logic [3:0] period;
    logic       locked;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   sparse = 1'b0;

  freq_meter #(.WIDTH(4), .LOCK_MATCHES(2)) dut (
    .clk(clk), .clr(clr), .count(count), .pulse(pulse),
    .period(period), .valid(valid), .locked(locked),
    .overflow(overflow), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] p, input logic l);
    exp_t e;
    e.period = p;
    e.locked = l;
    e.ovf    = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic p);
    pulse = p;
    count = sparse ? (cyc[0] == 1'b0) : 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hi();
    step(1'b1);
  endtask

  task automatic low(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic do_reset(input bit check_it);
    @(posedge clk);
    #1;
    clr   = 1'b1;
    pulse = 1'b0;
    #2;
    if (check_it) begin
      chk("reset_period", {4'd0, period}, 8'd0);
      chk("reset_flags", {5'd0, valid, locked, overflow}, 8'd0);
      chk("reset_state", {6'd0, state}, 8'd0);
    end
    #1;
    clr = 1'b0;
    low(1);
  endtask

  // Monitor: every valid strobe must match the oldest expected measurement
  always @(negedge clk) begin
    if (!clr && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual period %0d required no strobe", period);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_period", {4'd0, period}, {4'd0, e.period});
        chk("sb_locked", {7'd0, locked}, {7'd0, e.locked});
        chk("sb_overflow", {7'd0, overflow}, {7'd0, e.ovf});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr   = 1'b1;
    count = 1'b0;
    pulse = 1'b0;
    #12;
    do_reset(1'b1);

    // 1: F=5 loopback, lock on third edge
    hi(); low(5);
    push(4'd5, 1'b0); hi(); low(5);
    push(4'd5, 1'b1); hi(); low(2);
    chk("t1_locked", {7'd0, locked}, 8'd1);

    // 2: ticks on even cycles, edges every 10 cycles
    do_reset(1'b0);
    sparse = 1'b1;
    if (cyc % 2 != 0) low(1);
    hi(); low(9);
    push(4'd4, 1'b0); hi(); low(9);
    push(4'd4, 1'b1); hi(); low(2);
    sparse = 1'b0;

    // 3: overflow after 16 ticks, recovery
    do_reset(1'b0);
    hi(); low(15);
    chk("t3_state_pre", {6'd0, state}, 8'd1);
    chk("t3_ovf_pre", {7'd0, overflow}, 8'd0);
    low(1);
    chk("t3_state_over", {6'd0, state}, 8'd2);
    chk("t3_ovf_set", {7'd0, overflow}, 8'd1);
    low(3);
    hi();
    chk("t3_state_back", {6'd0, state}, 8'd1);
    chk("t3_ovf_sticky", {7'd0, overflow}, 8'd1);
    low(15);
    push(4'd15, 1'b0); hi();
    chk("t3_ovf_clear", {7'd0, overflow}, 8'd0);

    // 4: 16-cycle gap gives 15, 17-cycle gap overflows one cycle before the edge
    do_reset(1'b0);
    hi(); low(15);
    push(4'd15, 1'b0); hi();
    chk("t4_no_ovf", {7'd0, overflow}, 8'd0);
    chk("t4_state", {6'd0, state}, 8'd1);
    low(15);
    chk("t4_ovf_pre", {7'd0, overflow}, 8'd0);
    low(1);
    chk("t4_ovf_set", {7'd0, overflow}, 8'd1);
    hi();
    chk("t4_state_back", {6'd0, state}, 8'd1);

    // 5: 5, 5, 7 breaks lock on the 7
    do_reset(1'b0);
    hi(); low(5);
    push(4'd5, 1'b0); hi(); low(5);
    push(4'd5, 1'b1); hi(); low(7);
    push(4'd7, 1'b0); hi();
    chk("t5_unlocked", {7'd0, locked}, 8'd0);

    // 6: async clear while locked, release with pulse high
    do_reset(1'b0);
    hi(); low(5);
    push(4'd5, 1'b0); hi(); low(5);
    push(4'd5, 1'b1); hi(); low(2);
    chk("t6_locked", {7'd0, locked}, 8'd1);
    #1;
    clr   = 1'b1;
    pulse = 1'b1;
    #1;
    chk("t6_clr_period", {4'd0, period}, 8'd0);
    chk("t6_clr_flags", {5'd0, valid, locked, overflow}, 8'd0);
    chk("t6_clr_state", {6'd0, state}, 8'd0);
    #1;
    clr = 1'b0;
    step(1'b1); step(1'b1); step(1'b1);
    chk("t6_held_state", {6'd0, state}, 8'd0);
    low(1);
    hi();
    chk("t6_rearm_state", {6'd0, state}, 8'd1);
    low(3);

    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the interval between rising edges of a synchronous pulse stream, in enabled ticks, and reports it as a divide code. A `freqDivider`-style divider programmed with that code reproduces the measured period. It sits on the beat/tempo path of the rhythm game. It recovers the step interval of an incoming beat pulse so the game can re-time its own dividers, and it flags when the beat is steady (locked) or too slow to represent (overflow).

## Interface
Parameters:
- `WIDTH`, default 4: width of the measurement counter and of `period`. Matches the divider `freq` input.
- `LOCK_MATCHES`, default 2: number of consecutive identical valid measurements required to assert `locked`. Legal range is 1..15.

Ports:
- `clk`, input, 1: clock. All logic runs on its rising edge.
- `clr`, input, 1: reset, asynchronous, active-high.
- `count`, input, 1: tick enable. The counter advances only in cycles where it is 1.
- `pulse`, input, 1: beat pulse to measure. It is synchronous to `clk`.
- `period`, output, `WIDTH`: last valid measurement.
- `valid`, output, 1: one-cycle strobe when `period` is updated.
- `locked`, output, 1: the last `LOCK_MATCHES` valid measurements were identical, with no overflow in between.
- `overflow`, output, 1: sticky flag. The interval exceeded the maximum count of 2^WIDTH-1.
- `state`, output, 2: FSM state. 00 = IDLE, 01 = MEASURE, 10 = OVER.

## Operation
Edge detection:
- `pulse_q` registers `pulse` every cycle and resets to 1, so a level held high through reset release is not an edge.
- An edge occurs in a cycle where `pulse`=1 and `pulse_q`=0.

Counter:
- `cnt` is `WIDTH` bits and is loaded with 0 on every edge.
- In any other cycle, `cnt` increments when `count`=1 and the FSM is in MEASURE.
- `cnt` therefore counts the ticks strictly after edge E1, up to the cycle before edge E2.
- Example: with `count` held at 1 and edges every F+1 cycles, the measurement is F.

FSM:
- IDLE, on an edge: go to MEASURE with `cnt`=0. No `valid`.
- MEASURE, on an edge:
  - `period` <= `cnt` and `valid`=1 for one cycle.
  - `overflow` <= 0.
  - Update the lock logic.
  - Stay in MEASURE with `cnt` <= 0.
- MEASURE, no edge, `count`=1 and `cnt`=2^WIDTH-1:
  - Go to OVER. Set `overflow`=1 and `locked`=0, and clear the match counter.
  - `cnt` holds its value, and no wrap-around is allowed.
- OVER, on an edge: go to MEASURE with `cnt`=0. No `valid`. `overflow` stays 1.
- OVER, ticks are ignored.

Lock logic:
- `match` is a 4-bit saturating counter.
- On each valid measurement: if the new value equals the current `period` and `match`≠0, then `match` <= `match`+1 (saturating at 15). Otherwise `match` <= 1.
- `locked` = (`match` >= `LOCK_MATCHES`), updated in the same cycle as `valid`.

Simultaneous events:
- An edge has priority over a tick in the same cycle: the tick is discarded and `cnt` <= 0.
- An edge in the same cycle as the tick that would overflow yields a valid measurement of 2^WIDTH-1 and no overflow.

Reset:
- `clr` at any time, including mid-measurement, immediately forces:
  - `state`=IDLE.
  - `cnt`, `period`, `valid`, `locked`, `overflow` and `match` = 0.
  - `pulse_q`=1.

## Timing
- Reset values: `period`=0, `valid`=0, `locked`=0, `overflow`=0, `state`=00.
- Latency: when `pulse` is first sampled high at clock edge k, `valid`, `period`, `locked` and `state` change on edge k. They are visible during the cycle k..k+1.
- `valid` is high for exactly one cycle per measured interval.
- `period` holds its value between strobes.
- The first edge after reset or after OVER produces no strobe. The first measurement arrives on the second edge.
- Minimum interval between edges is 2 cycles. An edge every second cycle yields a measurement of 1 if the tick occurs between the edges.
- `overflow` sets on the clock edge of the overflowing tick. It clears on the next `valid`.

## Test plan
1. Divider loopback: `count`=1 and `pulse` high one cycle in every 6 (F=5).
   - Edge 1: no `valid`.
   - Edge 2: `valid`, `period`=5, `locked`=0.
   - Edge 3: `valid`, `period`=5, `locked`=1.
2. Sparse ticks: `count`=1 on even cycles only, with edges at even cycles every 10 cycles. Each `valid` reports `period`=4.
3. Overflow: `count`=1 and edges 20 cycles apart.
   - After 15 ticks, the next tick gives `state`=10 and `overflow`=1.
   - The next edge gives `state`=01 with no `valid`.
   - Then 15 cycles between edges gives `valid`, `period`=15, `overflow`=0.
4. Boundary: `count`=1 and edges 16 cycles apart.
   - Result: `period`=15, `valid` and no `overflow`, because the edge beats the tick.
   - With edges 17 cycles apart, `overflow`=1 one cycle before the edge.
5. Lock break: intervals giving 5, 5, 7.
   - `locked`=1 after the second 5.
   - On the `valid` with `period`=7, `locked`=0 in the same cycle.
6. Reset mid-measure: assert `clr` asynchronously between edges while in MEASURE with `locked`=1.
   - All outputs go to 0 and `state`=00 without waiting for a clock.
   - Release `clr` with `pulse` held high: no edge and no state change until `pulse` falls and rises again.
